// File: rtl/ethpipe_pkg.sv
// Shared types and constants for the ethpipe GMII datapath.
package ethpipe_pkg;

    localparam int unsigned LEN_W   = 11;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned PRE_LEN = 7;
    localparam int unsigned MIN_LEN = 60;
    localparam int unsigned FCS_LEN = 4;

    localparam logic [7:0]  PREAMBLE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic [3:0] {
        IDLE, PRE, SFD, DATA, PAD, FCS, ERR, DROP, IFG
    } state_t;

    typedef struct packed {
        logic [7:0] txd;
        logic       en;
        logic       er;
    } gmii_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide step of the reflected IEEE 802.3 CRC-32.
module crc32_d8
    import ethpipe_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  d,
    output logic [31:0] crc_next_c
);

    logic [31:0] work;

    // Bits enter LSB first, matching the order they go out on the wire.
    always_comb begin
        work = crc;
        for (int i = 0; i < 8; i++) begin
            work = (work >> 1) ^ ((work[0] ^ d[i]) ? CRC_POLY : 32'h0);
        end
        crc_next_c = work;
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload with zero padding, FCS, IFG,
// and abort with tx_er on underrun or oversize frames.
module gmii_tx_framer
    import ethpipe_pkg::*;
#(
    parameter int unsigned MAX_LEN = 1514,
    parameter int unsigned IFG_LEN = 12
) (
    input  logic        gmii_tx_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    input  logic        tx_last,
    output logic        tx_ready,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic [31:0] frame_cnt,
    output logic [15:0] err_cnt
);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [LEN_W-1:0]  len, len_n;
    logic [31:0]       crc, crc_n, crc_c;
    logic [31:0]       frame_n;
    logic [15:0]       err_n;
    gmii_t             gmii_q, gmii_n;
    logic [7:0]        crc_din;
    logic [7:0]        fcs_byte;
    logic              accept;

    // Length cap stops acceptance once MAX_LEN bytes are in without tx_last.
    assign tx_ready = (state == SFD) || (state == DROP) ||
                      ((state == DATA) && (len < LEN_W'(MAX_LEN)));
    assign accept   = tx_valid && tx_ready;
    assign crc_din  = (state == PAD) ? 8'h00 : tx_data;
    assign fcs_byte = 8'((~crc) >> {cnt[1:0], 3'b000});

    crc32_d8 u_crc (
        .crc        (crc),
        .d          (crc_din),
        .crc_next_c (crc_c)
    );

    // Next state and the wire byte for the following cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        len_n   = len;
        crc_n   = crc;
        frame_n = frame_cnt;
        err_n   = err_cnt;
        gmii_n  = '{txd: 8'h00, en: 1'b0, er: 1'b0};

        case (state)
            IDLE: begin
                crc_n = CRC_INIT;
                len_n = '0;
                cnt_n = '0;
                if (tx_valid) begin
                    state_n = PRE;
                    gmii_n  = '{txd: PREAMBLE, en: 1'b1, er: 1'b0};
                end
            end
            PRE: begin
                gmii_n = '{txd: PREAMBLE, en: 1'b1, er: 1'b0};
                cnt_n  = cnt + CNT_W'(1);
                if (cnt == CNT_W'(PRE_LEN - 1)) begin
                    gmii_n.txd = SFD_BYTE;
                    state_n    = SFD;
                    cnt_n      = '0;
                end
            end
            SFD, DATA: begin
                if (accept) begin
                    gmii_n  = '{txd: tx_data, en: 1'b1, er: 1'b0};
                    crc_n   = crc_c;
                    len_n   = len + LEN_W'(1);
                    state_n = DATA;
                    if (tx_last) begin
                        state_n = (len_n < LEN_W'(MIN_LEN)) ? PAD : FCS;
                        cnt_n   = '0;
                    end
                end else begin
                    // Underrun or length cap reached: abort on the next wire byte.
                    gmii_n  = '{txd: 8'h00, en: 1'b1, er: 1'b1};
                    state_n = ERR;
                end
            end
            PAD: begin
                gmii_n = '{txd: 8'h00, en: 1'b1, er: 1'b0};
                crc_n  = crc_c;
                len_n  = len + LEN_W'(1);
                if (len_n == LEN_W'(MIN_LEN)) begin
                    state_n = FCS;
                    cnt_n   = '0;
                end
            end
            FCS: begin
                gmii_n = '{txd: fcs_byte, en: 1'b1, er: 1'b0};
                cnt_n  = cnt + CNT_W'(1);
                if (cnt == CNT_W'(FCS_LEN - 1)) begin
                    frame_n = frame_cnt + 32'd1;
                    state_n = IFG;
                    cnt_n   = '0;
                end
            end
            ERR: begin
                err_n   = err_cnt + 16'd1;
                state_n = DROP;
            end
            DROP: begin
                if (accept && tx_last) begin
                    state_n = IFG;
                    cnt_n   = '0;
                end
            end
            IFG: begin
                // Runs IFG_LEN+1 cycles so the wire idles 13 byte times between frames.
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(IFG_LEN)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            len       <= '0;
            crc       <= CRC_INIT;
            gmii_q    <= '0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            len       <= len_n;
            crc       <= crc_n;
            gmii_q    <= gmii_n;
            frame_cnt <= frame_n;
            err_cnt   <= err_n;
        end
    end

    assign gmii_txd   = gmii_q.txd;
    assign gmii_tx_en = gmii_q.en;
    assign gmii_tx_er = gmii_q.er;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: captures the GMII wire and checks framing,
// padding, FCS residue, inter-frame gap, aborts and counters.
module tb_gmii_tx_framer;
    import ethpipe_pkg::*;

    logic        gmii_tx_clk = 1'b0;
    logic        sys_rst_n;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic [31:0] frame_cnt;
    logic [15:0] err_cnt;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [7:0]  pay [0:1599];
    logic [8:0]  wq [$];
    int          run = 0;
    int          last_run = 0;
    int          idle_run = 0;
    int          last_gap = -1;

    gmii_tx_framer dut (
        .gmii_tx_clk (gmii_tx_clk),
        .sys_rst_n   (sys_rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .gmii_txd    (gmii_txd),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 gmii_tx_clk = ~gmii_tx_clk;

    // Wire capture: every enabled byte as {er, txd}, plus run and gap lengths.
    always @(negedge gmii_tx_clk) begin
        if (!sys_rst_n) begin
            run      = 0;
            idle_run = 0;
        end else if (gmii_tx_en) begin
            if (run == 0) last_gap = idle_run;
            run++;
            idle_run = 0;
            wq.push_back({gmii_tx_er, gmii_txd});
        end else begin
            if (run != 0) last_run = run;
            run = 0;
            idle_run++;
        end
    end

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // MSB-first CRC-32 over captured bytes fed LSB first; data+FCS leaves the residue.
    function automatic logic [31:0] wire_crc(input int from, input int upto);
        logic [31:0] c = 32'hFFFFFFFF;
        logic [7:0]  b;
        for (int k = from; k < upto; k++) begin
            b = (k < wq.size()) ? wq[k][7:0] : 8'h00;
            for (int j = 0; j < 8; j++) begin
                if (c[31] ^ b[j]) c = (c << 1) ^ 32'h04C11DB7;
                else              c = c << 1;
            end
        end
        return c;
    endfunction

    function automatic logic [8:0] wq_at(input int k);
        return (k < wq.size()) ? wq[k] : 9'h1FF;
    endfunction

    task automatic check_frame(input string tag, input int off, input int n);
        int         len = (n < 60) ? 60 : n;
        int         bad_pre = 0;
        int         bad_data = 0;
        logic [8:0] e;
        for (int k = 0; k < 8; k++) begin
            e = (k == 7) ? {1'b0, 8'hD5} : {1'b0, 8'h55};
            if (wq_at(off + k) !== e) bad_pre++;
        end
        for (int k = 0; k < len; k++) begin
            e = {1'b0, (k < n) ? pay[k] : 8'h00};
            if (wq_at(off + 8 + k) !== e) bad_data++;
        end
        expect_eq({tag, "_preamble"}, bad_pre, 0);
        expect_eq({tag, "_payload"}, bad_data, 0);
        expect_eq({tag, "_fcs_residue"}, wire_crc(off + 8, off + 12 + len), CRC_RESIDUE);
    endtask

    // Offers n bytes; optional 2-cycle valid hole at index hole, or reset pulse at rst_at.
    task automatic send_frame(input int n, input int hole, input int rst_at);
        int i = 0;
        int cyc = 0;
        int hole_left = 2;
        while (i < n && cyc < 4000) begin
            @(negedge gmii_tx_clk);
            cyc++;
            if (i == rst_at) begin
                sys_rst_n = 1'b0;
                tx_valid  = 1'b0;
                tx_last   = 1'b0;
                #1;
                expect_eq("rst_mid_txd", gmii_txd, 0);
                expect_eq("rst_mid_en", gmii_tx_en, 0);
                expect_eq("rst_mid_er", gmii_tx_er, 0);
                expect_eq("rst_mid_ready", tx_ready, 0);
                expect_eq("rst_mid_frame_cnt", frame_cnt, 0);
                @(negedge gmii_tx_clk);
                sys_rst_n = 1'b1;
                return;
            end
            if (i == hole && hole_left > 0) begin
                tx_valid = 1'b0;
                hole_left--;
            end else begin
                tx_valid = 1'b1;
                tx_data  = pay[i];
                tx_last  = (i == n - 1);
            end
            if (tx_valid && tx_ready) i++;
        end
        expect_eq("handshake_done", i, n);
        @(negedge gmii_tx_clk);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        tx_valid  = 1'b0;
        tx_last   = 1'b0;
        tx_data   = 8'h00;
        repeat (3) @(negedge gmii_tx_clk);
        expect_eq("reset_txd", gmii_txd, 0);
        expect_eq("reset_en", gmii_tx_en, 0);
        expect_eq("reset_er", gmii_tx_er, 0);
        expect_eq("reset_ready", tx_ready, 0);
        expect_eq("reset_frame_cnt", frame_cnt, 0);
        expect_eq("reset_err_cnt", err_cnt, 0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge gmii_tx_clk);

        // 64-byte frame, incrementing payload.
        for (int k = 0; k < 64; k++) pay[k] = 8'(k);
        wq.delete();
        send_frame(64, -1, -1);
        repeat (80) @(negedge gmii_tx_clk);
        expect_eq("f64_bytes", wq.size(), 76);
        expect_eq("f64_en_run", last_run, 76);
        check_frame("f64", 0, 64);
        expect_eq("f64_frame_cnt", frame_cnt, 1);

        // 14-byte frame, padded with 46 zeros.
        for (int k = 0; k < 14; k++) pay[k] = 8'(8'hA0 + k);
        wq.delete();
        send_frame(14, -1, -1);
        repeat (80) @(negedge gmii_tx_clk);
        expect_eq("f14_bytes", wq.size(), 72);
        check_frame("f14", 0, 14);
        expect_eq("f14_frame_cnt", frame_cnt, 2);

        // Single byte with tx_last on the first byte.
        pay[0] = 8'h5A;
        wq.delete();
        send_frame(1, -1, -1);
        repeat (80) @(negedge gmii_tx_clk);
        expect_eq("f1_bytes", wq.size(), 72);
        check_frame("f1", 0, 1);
        expect_eq("f1_frame_cnt", frame_cnt, 3);

        // Two 60-byte frames back to back.
        for (int k = 0; k < 60; k++) pay[k] = 8'(8'hFF - k);
        wq.delete();
        send_frame(60, -1, -1);
        send_frame(60, -1, -1);
        repeat (100) @(negedge gmii_tx_clk);
        expect_eq("b2b_bytes", wq.size(), 144);
        expect_eq("b2b_gap", last_gap, 13);
        check_frame("b2b_a", 0, 60);
        check_frame("b2b_b", 72, 60);
        expect_eq("b2b_frame_cnt", frame_cnt, 5);

        // Underrun after byte 20 of a 50-byte frame.
        for (int k = 0; k < 50; k++) pay[k] = 8'(8'h30 + k);
        wq.delete();
        send_frame(50, 20, -1);
        repeat (40) @(negedge gmii_tx_clk);
        expect_eq("urun_bytes", wq.size(), 29);
        expect_eq("urun_last_data", wq_at(27), {1'b0, pay[19]});
        expect_eq("urun_err_byte", wq_at(28), {1'b1, 8'h00});
        expect_eq("urun_err_cnt", err_cnt, 1);
        expect_eq("urun_frame_cnt", frame_cnt, 5);

        // 1600-byte frame against the 1514 cap.
        for (int k = 0; k < 1600; k++) pay[k] = 8'(k + 3);
        wq.delete();
        send_frame(1600, -1, -1);
        repeat (40) @(negedge gmii_tx_clk);
        expect_eq("ovsz_bytes", wq.size(), 1523);
        expect_eq("ovsz_last_data", wq_at(1521), {1'b0, pay[1513]});
        expect_eq("ovsz_err_byte", wq_at(1522), {1'b1, 8'h00});
        expect_eq("ovsz_err_cnt", err_cnt, 2);
        expect_eq("ovsz_frame_cnt", frame_cnt, 5);

        // Reset during byte 30, then a clean 60-byte frame.
        for (int k = 0; k < 64; k++) pay[k] = 8'(8'h11 * k);
        send_frame(64, -1, 30);
        repeat (3) @(negedge gmii_tx_clk);
        expect_eq("post_rst_err_cnt", err_cnt, 0);
        wq.delete();
        send_frame(60, -1, -1);
        repeat (80) @(negedge gmii_tx_clk);
        expect_eq("post_rst_bytes", wq.size(), 72);
        check_frame("post_rst", 0, 60);
        expect_eq("post_rst_frame_cnt", frame_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
